// File: rtl/aes_inv_subbytes.sv
// AES inverse SubBytes: substitutes an NxN byte state through the inverse S-box, one byte per cycle.
// Define AES_INV_SUBBYTES_ROW_PARALLEL_EN to substitute a whole row per cycle instead.
module aes_inv_subbytes #(
  parameter int STATE_ARRAY_DIMENSION = 4
) (
  input  logic                                                       clk,
  input  logic                                                       reset,
  input  logic                                                       valid,
  input  logic                                                       next_is_ready,
  input  logic [STATE_ARRAY_DIMENSION-1:0][STATE_ARRAY_DIMENSION-1:0][7:0] state_array,
  output logic [STATE_ARRAY_DIMENSION-1:0][STATE_ARRAY_DIMENSION-1:0][7:0] state_array_out,
  output logic                                                       ready,
  output logic                                                       valid_out
);

  localparam int N  = STATE_ARRAY_DIMENSION;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Inverse S-box, byte 0x00 first; each 128-bit word is one row of the table.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                        state;
  logic [CW-1:0]                 current_word_coords [2];
  logic [N-1:0][N-1:0][7:0]      buf_q;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      ready                  <= 1'b1;
      valid_out              <= 1'b0;
      state_array_out        <= '0;
      buf_q                  <= '0;
      current_word_coords[0] <= '0;
      current_word_coords[1] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            buf_q                  <= state_array;
            current_word_coords[0] <= '0;
            current_word_coords[1] <= '0;
            ready                  <= 1'b0;
            state                  <= BUSY;
          end
        end
        BUSY: begin
`ifdef AES_INV_SUBBYTES_ROW_PARALLEL_EN
          for (int c = 0; c < N; c++) begin
            state_array_out[current_word_coords[0]][c] <=
              inv_sbox(buf_q[current_word_coords[0]][c]);
          end
          current_word_coords[1] <= '0;
          if (current_word_coords[0] == LAST) begin
            current_word_coords[0] <= '0;
            valid_out              <= 1'b1;
            state                  <= DONE;
          end else begin
            current_word_coords[0] <= current_word_coords[0] + CW'(1);
          end
`else
          state_array_out[current_word_coords[0]][current_word_coords[1]] <=
            inv_sbox(buf_q[current_word_coords[0]][current_word_coords[1]]);
          if (current_word_coords[1] == LAST) begin
            current_word_coords[1] <= '0;
            if (current_word_coords[0] == LAST) begin
              current_word_coords[0] <= '0;
              valid_out              <= 1'b1;
              state                  <= DONE;
            end else begin
              current_word_coords[0] <= current_word_coords[0] + CW'(1);
            end
          end else begin
            current_word_coords[1] <= current_word_coords[1] + CW'(1);
          end
`endif
        end
        DONE: begin
          // Result is held until the downstream stage takes it.
          if (next_is_ready) begin
            valid_out <= 1'b0;
            ready     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_subbytes.sv
// Testbench for aes_inv_subbytes: randomized arrays checked against a GF(2^8)-derived S-box model.
module tb_aes_inv_subbytes;

  localparam int N = 4;
`ifdef AES_INV_SUBBYTES_ROW_PARALLEL_EN
  localparam int LAT = N;
`else
  localparam int LAT = N * N;
`endif

  typedef logic [N-1:0][N-1:0][7:0] arr_t;

  logic clk = 1'b0;
  logic reset, valid, next_is_ready;
  arr_t state_array, state_array_out;
  logic ready, valid_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] sbox_m [256];
  logic [7:0] inv_m  [256];

  aes_inv_subbytes #(.STATE_ARRAY_DIMENSION(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .valid           (valid),
    .next_is_ready   (next_is_ready),
    .state_array     (state_array),
    .state_array_out (state_array_out),
    .ready           (ready),
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  // Forward S-box from multiplicative inverse + affine map; inverse by inverting that mapping.
  task automatic build_model();
    logic [7:0] a8, b8, inv, s;
    for (int a = 0; a < 256; a++) begin
      a8  = 8'(a);
      inv = 8'h00;
      if (a != 0) begin
        for (int b = 1; b < 256; b++) begin
          b8 = 8'(b);
          if (gmul(a8, b8) == 8'h01) inv = b8;
        end
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_m[a] = s;
      inv_m[s]  = a8;
    end
  endtask

  function automatic arr_t model_inv(input arr_t a);
    arr_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[i][j] = inv_m[a[i][j]];
    return r;
  endfunction

  function automatic arr_t model_fwd(input arr_t a);
    arr_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[i][j] = sbox_m[a[i][j]];
    return r;
  endfunction

  function automatic arr_t rand_arr();
    arr_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[i][j] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // Drives one array through; returns result, edges from acceptance to valid_out, and ready after accept.
  task automatic send_array(input arr_t a, output arr_t res, output int lat, output logic rdy_after);
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 200) begin tick(); w++; end
    state_array = a;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    rdy_after = ready;
    lat = 0;
    while (valid_out !== 1'b1 && lat < 200) begin tick(); lat++; end
    res = state_array_out;
  endtask

  task automatic test_reset();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
    total++;
    if (state_array_out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", state_array_out); end
    total++;
    if (dut.current_word_coords[0] !== '0 || dut.current_word_coords[1] !== '0) begin
      bad++;
      $display("FAIL reset_coords got=%0d,%0d exp=0,0", dut.current_word_coords[0], dut.current_word_coords[1]);
    end
  endtask

  task automatic test_reset_mid_busy();
    arr_t a, res;
    int lat, k;
    logic ra;
    k = (LAT > 5) ? 5 : LAT - 1;
    a = rand_arr();
    state_array = a;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (k) tick();
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL midbusy_early_valid got=%b exp=0", valid_out); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL midbusy_ready got=%b exp=1", ready); end
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL midbusy_valid_out got=%b exp=0", valid_out); end
    total++;
    if (state_array_out !== '0) begin bad++; $display("FAIL midbusy_out got=%h exp=0", state_array_out); end
    tick();
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL midbusy_no_result got=%b exp=0", valid_out); end
    a = rand_arr();
    send_array(a, res, lat, ra);
    total++;
    if (res !== model_inv(a)) begin bad++; $display("FAIL midbusy_next got=%h exp=%h", res, model_inv(a)); end
    tick();
  endtask

  task automatic test_all_63();
    arr_t a, res, z;
    int lat;
    logic ra;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) a[i][j] = 8'h63;
    z = '0;
    next_is_ready = 1'b1;
    send_array(a, res, lat, ra);
    total++;
    if (ra !== 1'b0) begin bad++; $display("FAIL all63_ready_low got=%b exp=0", ra); end
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL all63_latency got=%0d exp=%0d", lat, LAT); end
    total++;
    if (res !== z) begin bad++; $display("FAIL all63_out got=%h exp=%h", res, z); end
    tick();
    total++;
    if (valid_out !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL all63_done_one_cycle got valid_out=%b ready=%b exp 0/1", valid_out, ready);
    end
  endtask

  task automatic test_vector();
    logic [7:0] vin  [4][4] = '{'{8'hd4, 8'he0, 8'hb8, 8'h1e}, '{8'h27, 8'hbf, 8'hb4, 8'h41},
                                '{8'h11, 8'h98, 8'h5d, 8'h52}, '{8'hae, 8'hf1, 8'he5, 8'h30}};
    logic [7:0] vexp [4][4] = '{'{8'h19, 8'ha0, 8'h9a, 8'he9}, '{8'h3d, 8'hf4, 8'hc6, 8'hf8},
                                '{8'he3, 8'he2, 8'h8d, 8'h48}, '{8'hbe, 8'h2b, 8'h2a, 8'h08}};
    arr_t a, e, res;
    int lat;
    logic ra;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      a[i][j] = vin[i][j];
      e[i][j] = vexp[i][j];
    end
    next_is_ready = 1'b1;
    send_array(a, res, lat, ra);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL vector_latency got=%0d exp=%0d", lat, LAT); end
    total++;
    if (res !== e) begin bad++; $display("FAIL vector_out got=%h exp=%h", res, e); end
    total++;
    if (model_inv(a) !== e) begin bad++; $display("FAIL vector_model got=%h exp=%h", model_inv(a), e); end
    tick();
  endtask

  task automatic test_spot();
    arr_t a, res;
    int lat;
    logic ra;
    a = rand_arr();
    a[0][0] = 8'h00; a[0][1] = 8'h63; a[0][2] = 8'h7c; a[0][3] = 8'h16;
    next_is_ready = 1'b1;
    send_array(a, res, lat, ra);
    total++;
    if (res[0] !== {8'hff, 8'h01, 8'h00, 8'h52}) begin
      bad++;
      $display("FAIL spot_values got=%h exp=ff010052", res[0]);
    end
    total++;
    if (res !== model_inv(a)) begin bad++; $display("FAIL spot_rest got=%h exp=%h", res, model_inv(a)); end
    tick();
  endtask

  task automatic test_hold();
    arr_t a, e, res;
    int lat;
    logic ra;
    a = rand_arr();
    e = model_inv(a);
    next_is_ready = 1'b0;
    send_array(a, res, lat, ra);
    total++;
    if (res !== e) begin bad++; $display("FAIL hold_first got=%h exp=%h", res, e); end
    for (int i = 0; i < 10; i++) begin
      valid = i[0];
      state_array = rand_arr();
      tick();
      total++;
      if (valid_out !== 1'b1 || ready !== 1'b0 || state_array_out !== e) begin
        bad++;
        $display("FAIL hold_cycle%0d got valid_out=%b ready=%b out=%h exp 1/0/%h",
                 i, valid_out, ready, state_array_out, e);
      end
    end
    valid = 1'b0;
    next_is_ready = 1'b1;
    tick();
    total++;
    if (valid_out !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_release got valid_out=%b ready=%b exp 0/1", valid_out, ready);
    end
    tick();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL hold_no_late_accept got=%b exp=1", ready); end
  endtask

  task automatic test_round_trip();
    arr_t orig, res;
    int lat, errs;
    logic ra;
    errs = 0;
    next_is_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      orig = rand_arr();
      send_array(model_fwd(orig), res, lat, ra);
      total++;
      if (res !== orig || lat !== LAT) begin
        bad++;
        $display("FAIL round_trip%0d got=%h lat=%0d exp=%h lat=%0d", n, res, lat, orig, LAT);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    arr_t a;
    int acc[$];
    int cyc;
    a = rand_arr();
    state_array = a;
    next_is_ready = 1'b1;
    valid = 1'b1;
    cyc = 0;
    while (acc.size() < 3 && cyc < 200) begin
      if (ready === 1'b1) acc.push_back(cyc);
      tick();
      cyc++;
    end
    valid = 1'b0;
    total++;
    if (acc.size() != 3) begin
      bad++;
      $display("FAIL b2b_accepts got=%0d exp=3", acc.size());
    end else begin
      total++;
      if (acc[1] - acc[0] != LAT + 2 || acc[2] - acc[1] != LAT + 2) begin
        bad++;
        $display("FAIL b2b_period got=%0d,%0d exp=%0d", acc[1] - acc[0], acc[2] - acc[1], LAT + 2);
      end
    end
    cyc = 0;
    while (valid_out !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    total++;
    if (state_array_out !== model_inv(a)) begin
      bad++;
      $display("FAIL b2b_out got=%h exp=%h", state_array_out, model_inv(a));
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    next_is_ready = 1'b0;
    state_array = '0;
    build_model();
    repeat (2) tick();
    reset = 1'b0;
    test_reset();
    test_reset_mid_busy();
    test_all_63();
    test_vector();
    test_spot();
    test_hold();
    test_round_trip();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
